// File: rtl/pos_cache_dbuf_mc_if.sv
// Broadcast-ingest and read-port bundle for pos_cache_dbuf_mc.
// master = broadcast source / force-pipeline side, slave = the cache.
interface pos_cache_dbuf_mc_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned NUM_CH        = 2
);
  logic                              motion_update_enable;
  logic [NUM_CH*3*DATA_WIDTH-1:0]    in_data;
  logic [NUM_CH*3*CELL_ID_WIDTH-1:0] in_data_dst_cell;
  logic [NUM_CH-1:0]                 in_data_valid;
  logic                              in_ready;
  logic [ADDR_WIDTH-1:0]             in_read_address;
  logic                              in_rden;
  logic [3*DATA_WIDTH-1:0]           out_particle_info;
  logic                              out_active_bank;
  logic                              out_swap_done;
  logic                              out_overflow;

  modport master (
    output motion_update_enable, in_data, in_data_dst_cell, in_data_valid,
    output in_read_address, in_rden,
    input  in_ready, out_particle_info, out_active_bank, out_swap_done, out_overflow
  );

  modport slave (
    input  motion_update_enable, in_data, in_data_dst_cell, in_data_valid,
    input  in_read_address, in_rden,
    output in_ready, out_particle_info, out_active_bank, out_swap_done, out_overflow
  );
endinterface

// File: rtl/pos_cache_dbuf_mc.sv
// Double-buffered per-cell position cache. The active bank serves reads; the
// shadow bank is filled from a multi-channel broadcast through an ingest FIFO,
// then stamped with the particle count at address 0 and swapped in.
// Optional build macro: POS_CACHE_READ_REG_EN adds a second read output stage.
module pos_cache_dbuf_mc #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned PARTICLE_NUM  = 220,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned CELL_X        = 1,
  parameter int unsigned CELL_Y        = 1,
  parameter int unsigned CELL_Z        = 1,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned INIT_COUNT    = 0
) (
  input logic               clk,
  input logic               rst,
  pos_cache_dbuf_mc_if.slave bus
);

  localparam int unsigned PW    = 3 * DATA_WIDTH;
  localparam int unsigned CW3   = 3 * CELL_ID_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FC_W  = FA_W + 1;

  localparam logic [CW3-1:0]   MY_CELL  = {CELL_ID_WIDTH'(CELL_X), CELL_ID_WIDTH'(CELL_Y),
                                           CELL_ID_WIDTH'(CELL_Z)};
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(PARTICLE_NUM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_WRITE_NUM,
    S_SWAP
  } state_t;

  typedef logic [PW-1:0] bank_t [DEPTH];

  // Power-up image of bank 0: count at address 0, a simple ramp of particles after it.
  function automatic bank_t f_bank0_image();
    bank_t img;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (a == 0)
        img[a] = PW'(INIT_COUNT);
      else if (a <= INIT_COUNT)
        img[a] = {DATA_WIDTH'(a), DATA_WIDTH'(a), DATA_WIDTH'(a)};
      else
        img[a] = '0;
    end
    return img;
  endfunction

  bank_t r_bank0 = f_bank0_image();
  bank_t r_bank1 = '{default: '0};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_pop;
  logic              w_clr_ovf;
  logic              w_wr_num;
  logic              w_swap;

  logic [PW-1:0]     r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]   r_fifo_wp;
  logic [FA_W-1:0]   r_fifo_rp;
  logic [FC_W-1:0]   r_fifo_cnt;
  logic [FC_W-1:0]   w_fifo_cnt_nxt;
  logic              r_in_ready;
  logic              w_ready_nxt;

  logic [NUM_CH-1:0] w_match;
  logic [FA_W-1:0]   w_fifo_widx [NUM_CH];
  logic [FC_W-1:0]   w_push_n;

  logic [PTR_W-1:0]      r_wr_ptr;
  logic                  r_overflow;
  logic                  r_active_bank;
  logic                  r_swap_done;
  logic                  w_bank_we;
  logic [ADDR_WIDTH-1:0] w_bank_wa;
  logic [PW-1:0]         w_bank_wd;
  logic [PW-1:0]         r_rd_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    w_clr_ovf   = 1'b0;
    w_wr_num    = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.motion_update_enable) begin
          w_state_nxt = S_COLLECT;
          w_accept    = r_in_ready;
          w_clr_ovf   = 1'b1;
        end
      end
      S_COLLECT: begin
        w_pop = (r_fifo_cnt != '0);
        if (bus.motion_update_enable) w_accept    = r_in_ready;
        else                          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_fifo_cnt == '0) w_state_nxt = S_WRITE_NUM;
        else                  w_pop       = 1'b1;
      end
      S_WRITE_NUM: begin
        w_wr_num    = 1'b1;
        w_state_nxt = S_SWAP;
      end
      S_SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Channel match and compaction: matches take consecutive FIFO slots, channel 0 first.
  always_comb begin
    w_match     = '0;
    w_push_n    = '0;
    w_fifo_widx = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      w_match[c]     = bus.in_data_valid[c] &&
                       (bus.in_data_dst_cell[c*CW3 +: CW3] == MY_CELL);
      w_fifo_widx[c] = r_fifo_wp + FA_W'(w_push_n);
      if (w_match[c]) w_push_n = w_push_n + FC_W'(1);
    end
    if (!w_accept) w_push_n = '0;
  end

  // Occupancy after this cycle's push and pop drives next-cycle ready.
  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt + w_push_n - FC_W'(w_pop);
    w_ready_nxt    = (FC_W'(FIFO_DEPTH) - w_fifo_cnt_nxt) >= FC_W'(NUM_CH);
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_fifo_cnt <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_fifo_wp  <= r_fifo_wp + FA_W'(w_push_n);
      r_fifo_rp  <= r_fifo_rp + FA_W'(w_pop);
      r_fifo_cnt <= w_fifo_cnt_nxt;
      r_in_ready <= w_ready_nxt;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst && w_accept && w_match[c])
        r_fifo[w_fifo_widx[c]] <= bus.in_data[c*PW +: PW];
    end
  end

  // Shadow write pointer (saturates at the overflow slot) and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= PTR_W'(1);
      r_overflow <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_wr_ptr <= PTR_W'(1);
      else if (w_pop && (r_wr_ptr != PTR_FULL))
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_clr_ovf)
        r_overflow <= 1'b0;
      else if (w_pop && (r_wr_ptr == PTR_FULL))
        r_overflow <= 1'b1;
    end
  end

  // Shadow-bank write port: count stamp or drained particle.
  always_comb begin
    w_bank_we = 1'b0;
    w_bank_wa = '0;
    w_bank_wd = r_fifo[r_fifo_rp];
    if (w_wr_num) begin
      w_bank_we = 1'b1;
      w_bank_wd = PW'(r_wr_ptr - PTR_W'(1));
    end else if (w_pop && (r_wr_ptr != PTR_FULL)) begin
      w_bank_we = 1'b1;
      w_bank_wa = ADDR_WIDTH'(r_wr_ptr);
    end
  end

  // Bank storage; only the bank not serving reads is written.
  always_ff @(posedge clk) begin
    if (!rst && w_bank_we) begin
      if (r_active_bank) r_bank0[w_bank_wa] <= w_bank_wd;
      else               r_bank1[w_bank_wa] <= w_bank_wd;
    end
  end

  // Bank select and swap pulse change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active_bank <= 1'b0;
      r_swap_done   <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      if (w_swap) r_active_bank <= ~r_active_bank;
    end
  end

  // Read port on the active bank; holds when not enabled.
  always_ff @(posedge clk) begin
    if (rst)
      r_rd_data <= '0;
    else if (bus.in_rden)
      r_rd_data <= r_active_bank ? r_bank1[bus.in_read_address]
                                 : r_bank0[bus.in_read_address];
  end

`ifdef POS_CACHE_READ_REG_EN
  logic          r_rd_vld;
  logic [PW-1:0] r_rd_data_q;

  // Extra output stage, loaded only behind a real read so the output still holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld    <= 1'b0;
      r_rd_data_q <= '0;
    end else begin
      r_rd_vld <= bus.in_rden;
      if (r_rd_vld) r_rd_data_q <= r_rd_data;
    end
  end

  assign bus.out_particle_info = r_rd_data_q;
`else
  assign bus.out_particle_info = r_rd_data;
`endif

  assign bus.in_ready        = r_in_ready;
  assign bus.out_active_bank = r_active_bank;
  assign bus.out_swap_done   = r_swap_done;
  assign bus.out_overflow    = r_overflow;

endmodule

// File: tb/tb_pos_cache_dbuf_mc.sv
// Bench for pos_cache_dbuf_mc: instance A uses default sizing, instance B a
// tiny FIFO and capacity to exercise back-pressure and overflow.
module tb_pos_cache_dbuf_mc;

`ifdef POS_CACHE_READ_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [11:0] MY    = {4'd1, 4'd1, 4'd1};
  localparam logic [11:0] OTHER = {4'd1, 4'd2, 4'd1};

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp = 0;
  int n_err = 0;

  pos_cache_dbuf_mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CELL_ID_WIDTH(4), .NUM_CH(2)) bus_a ();
  pos_cache_dbuf_mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CELL_ID_WIDTH(4), .NUM_CH(2)) bus_b ();

  pos_cache_dbuf_mc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .PARTICLE_NUM(220), .CELL_ID_WIDTH(4),
    .CELL_X(1), .CELL_Y(1), .CELL_Z(1), .NUM_CH(2), .FIFO_DEPTH(16), .INIT_COUNT(7)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  pos_cache_dbuf_mc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .PARTICLE_NUM(12), .CELL_ID_WIDTH(4),
    .CELL_X(1), .CELL_Y(1), .CELL_Z(1), .NUM_CH(2), .FIFO_DEPTH(4), .INIT_COUNT(0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [1:0] hit;
    logic       exp_ready;
  } bvec_t;

  bvec_t        tbl [9];
  logic [95:0]  exp_q [$];
  logic [95:0]  expb_q [$];
  logic [95:0]  rd;
  logic [95:0]  held;
  int           pulses;
  int           seq;
  bit           saw_nr;

  function automatic logic [95:0] pdata(input int k);
    return {32'(k + 30000), 32'(k + 20000), 32'(k + 10000)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_a(input int addr, output logic [95:0] d);
    bus_a.in_read_address = 8'(addr);
    bus_a.in_rden         = 1'b1;
    tick();
    bus_a.in_rden = 1'b0;
    for (int i = 1; i < RD_LAT; i++) tick();
    d = bus_a.out_particle_info;
  endtask

  task automatic read_b(input int addr, output logic [95:0] d);
    bus_b.in_read_address = 4'(addr);
    bus_b.in_rden         = 1'b1;
    tick();
    bus_b.in_rden = 1'b0;
    for (int i = 1; i < RD_LAT; i++) tick();
    d = bus_b.out_particle_info;
  endtask

  task automatic wait_swap_a(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_a.out_swap_done) n++;
    end
  endtask

  task automatic wait_swap_b(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_b.out_swap_done) n++;
    end
  endtask

  // Offer both-channel matches on B until n_acc cycles are accepted, then drop enable.
  task automatic run_b(input int n_acc, input int base, output bit nr);
    int acc;
    int guard;
    acc   = 0;
    guard = 0;
    nr    = 1'b0;
    bus_b.motion_update_enable = 1'b1;
    bus_b.in_data_valid        = 2'b11;
    bus_b.in_data_dst_cell     = {MY, MY};
    while (acc < n_acc && guard < 200) begin
      bus_b.in_data = {pdata(base + 2*acc + 1), pdata(base + 2*acc)};
      if (bus_b.in_ready) begin
        expb_q.push_back(pdata(base + 2*acc));
        expb_q.push_back(pdata(base + 2*acc + 1));
        acc++;
      end else begin
        nr = 1'b1;
      end
      tick();
      guard++;
    end
    check("b_accept_bound", 96'(acc), 96'(n_acc));
    bus_b.motion_update_enable = 1'b0;
    bus_b.in_data_valid        = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v: 2'b11, hit: 2'b11, exp_ready: 1'b1};
    tbl[1] = '{v: 2'b11, hit: 2'b11, exp_ready: 1'b1};
    tbl[2] = '{v: 2'b11, hit: 2'b11, exp_ready: 1'b1};
    tbl[3] = '{v: 2'b11, hit: 2'b11, exp_ready: 1'b1};
    tbl[4] = '{v: 2'b11, hit: 2'b11, exp_ready: 1'b1};
    tbl[5] = '{v: 2'b01, hit: 2'b01, exp_ready: 1'b1};
    tbl[6] = '{v: 2'b11, hit: 2'b10, exp_ready: 1'b1};
    tbl[7] = '{v: 2'b10, hit: 2'b00, exp_ready: 1'b1};
    tbl[8] = '{v: 2'b00, hit: 2'b11, exp_ready: 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.motion_update_enable = 1'b0;
    bus_a.in_data              = '0;
    bus_a.in_data_dst_cell     = '0;
    bus_a.in_data_valid        = '0;
    bus_a.in_read_address      = '0;
    bus_a.in_rden              = 1'b0;
    bus_b.motion_update_enable = 1'b0;
    bus_b.in_data              = '0;
    bus_b.in_data_dst_cell     = '0;
    bus_b.in_data_valid        = '0;
    bus_b.in_read_address      = '0;
    bus_b.in_rden              = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Reset state and power-up image of bank 0.
    check("rst_ready",     96'(bus_a.in_ready), 96'd1);
    check("rst_bank",      96'(bus_a.out_active_bank), 96'd0);
    check("rst_swap_done", 96'(bus_a.out_swap_done), 96'd0);
    check("rst_overflow",  96'(bus_a.out_overflow), 96'd0);
    check("rst_rdata",     bus_a.out_particle_info, 96'd0);
    read_a(0, rd);
    check("init_count", rd, 96'd7);
    read_a(3, rd);
    check("init_addr3", rd, {32'd3, 32'd3, 32'd3});
    held = rd;
    tick();
    tick();
    check("rd_hold", bus_a.out_particle_info, held);
    read_a(9, rd);
    check("init_addr9", rd, 96'd0);

    // Table-driven update on A; first vector lands in the IDLE cycle.
    seq = 0;
    for (int i = 0; i < 9; i++) begin
      bus_a.motion_update_enable = 1'b1;
      bus_a.in_data_valid        = tbl[i].v;
      bus_a.in_data_dst_cell     = {tbl[i].hit[1] ? MY : OTHER, tbl[i].hit[0] ? MY : OTHER};
      bus_a.in_data              = {pdata(seq + 1), pdata(seq)};
      check($sformatf("a_ready[%0d]", i), 96'(bus_a.in_ready), 96'(tbl[i].exp_ready));
      if (bus_a.in_ready) begin
        for (int c = 0; c < 2; c++)
          if (tbl[i].v[c] && tbl[i].hit[c]) exp_q.push_back(pdata(seq + c));
      end
      seq += 2;
      tick();
    end
    // Falling cycle carries matches that must be ignored.
    bus_a.motion_update_enable = 1'b0;
    bus_a.in_data_valid        = 2'b11;
    bus_a.in_data_dst_cell     = {MY, MY};
    bus_a.in_data              = {pdata(901), pdata(900)};
    tick();
    bus_a.in_data_valid = 2'b00;
    wait_swap_a(pulses);
    check("a_swap_pulses", 96'(pulses), 96'd1);
    check("a_bank",        96'(bus_a.out_active_bank), 96'd1);
    check("a_overflow",    96'(bus_a.out_overflow), 96'd0);
    read_a(0, rd);
    check("a_count", rd, 96'(exp_q.size()));
    for (int k = 1; k <= exp_q.size(); k++) begin
      read_a(k, rd);
      check($sformatf("a_addr%0d", k), rd, exp_q[k-1]);
    end
    read_a(exp_q.size() + 1, rd);
    check("a_after_last", rd, 96'd0);

    // Reset during DRAIN with entries still queued.
    bus_a.motion_update_enable = 1'b1;
    bus_a.in_data_valid        = 2'b11;
    bus_a.in_data_dst_cell     = {MY, MY};
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data = {pdata(501 + 2*i), pdata(500 + 2*i)};
      tick();
    end
    bus_a.motion_update_enable = 1'b0;
    bus_a.in_data_valid        = 2'b00;
    tick();
    tick();
    rst_a = 1'b1;
    tick();
    check("rstd_bank",      96'(bus_a.out_active_bank), 96'd0);
    check("rstd_swap_done", 96'(bus_a.out_swap_done), 96'd0);
    check("rstd_ready",     96'(bus_a.in_ready), 96'd1);
    rst_a = 1'b0;
    wait_swap_a(pulses);
    check("rstd_no_swap", 96'(pulses), 96'd0);
    read_a(0, rd);
    check("rstd_bank0_count", rd, 96'd7);

    // Window with no matching destination: count 0 is still written and swapped in.
    bus_a.motion_update_enable = 1'b1;
    bus_a.in_data_valid        = 2'b11;
    bus_a.in_data_dst_cell     = {OTHER, OTHER};
    for (int i = 0; i < 4; i++) tick();
    bus_a.motion_update_enable = 1'b0;
    bus_a.in_data_valid        = 2'b00;
    wait_swap_a(pulses);
    check("e_swap_pulses", 96'(pulses), 96'd1);
    check("e_bank",        96'(bus_a.out_active_bank), 96'd1);
    read_a(0, rd);
    check("e_count", rd, 96'd0);
    read_a(1, rd);
    check("e_addr1_kept", rd, exp_q[0]);

    // B: back-pressure with a 4-entry FIFO, no loss of held inputs.
    expb_q.delete();
    run_b(5, 100, saw_nr);
    check("b1_saw_not_ready", 96'(saw_nr), 96'd1);
    wait_swap_b(pulses);
    check("b1_swap_pulses", 96'(pulses), 96'd1);
    check("b1_bank",        96'(bus_b.out_active_bank), 96'd1);
    check("b1_overflow",    96'(bus_b.out_overflow), 96'd0);
    read_b(0, rd);
    check("b1_count", rd, 96'd10);
    for (int k = 1; k <= 10; k++) begin
      read_b(k, rd);
      check($sformatf("b1_addr%0d", k), rd, expb_q[k-1]);
    end

    // B: 14 matches into a 12-particle bank.
    expb_q.delete();
    run_b(7, 200, saw_nr);
    wait_swap_b(pulses);
    check("b2_swap_pulses", 96'(pulses), 96'd1);
    check("b2_bank",        96'(bus_b.out_active_bank), 96'd0);
    check("b2_overflow",    96'(bus_b.out_overflow), 96'd1);
    read_b(0, rd);
    check("b2_count", rd, 96'd12);
    read_b(1, rd);
    check("b2_addr1", rd, expb_q[0]);
    read_b(12, rd);
    check("b2_addr12", rd, expb_q[11]);

    // Overflow is sticky through IDLE and clears on the next enable rise.
    check("b3_ovf_sticky", 96'(bus_b.out_overflow), 96'd1);
    bus_b.motion_update_enable = 1'b1;
    tick();
    check("b3_ovf_cleared", 96'(bus_b.out_overflow), 96'd0);
    bus_b.motion_update_enable = 1'b0;
    wait_swap_b(pulses);
    check("b3_swap_pulses", 96'(pulses), 96'd1);
    read_b(0, rd);
    check("b3_count", rd, 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pos_cache_dbuf_mc.md
# pos_cache_dbuf_mc

Parametrised double-buffered per-cell position cache for the range-limited LJ pipeline. One bank serves position reads to the force pipelines. The shadow bank collects particles broadcast by the motion-update unit over NUM_CH parallel channels, buffered through an ingest FIFO. At the end of motion update the block writes the new particle count to address 0 and swaps banks. Capacity overflow is detected and reported, not silently wrapped.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one coordinate; a particle word is 3*DATA_WIDTH, packed {posz, posy, posx}.
- ADDR_WIDTH, 8, bank address width.
- PARTICLE_NUM, 220, maximum particles per bank, excluding address 0; must be at most 2^ADDR_WIDTH-1.
- CELL_ID_WIDTH, 4, width of each cell coordinate.
- CELL_X / CELL_Y / CELL_Z, 1 / 1 / 1, this cell's ID.
- NUM_CH, 2, number of broadcast channels, 1..4.
- FIFO_DEPTH, 16, ingest FIFO entries; a power of two, at least 2*NUM_CH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- motion_update_enable  in  1  high for the whole broadcast window.
- in_data  in  NUM_CH*3*DATA_WIDTH  channel c occupies slice c.
- in_data_dst_cell  in  NUM_CH*3*CELL_ID_WIDTH  per channel {x,y,z}.
- in_data_valid  in  NUM_CH  per-channel valid.
- in_ready  out  1  broadcast accepted this cycle.
- in_read_address  in  ADDR_WIDTH  read address into the active bank.
- in_rden  in  1  read enable.
- out_particle_info  out  3*DATA_WIDTH  read data.
- out_active_bank  out  1  bank currently serving reads.
- out_swap_done  out  1  one-cycle pulse when the swap completes.
- out_overflow  out  1  sticky: particles were dropped in the current or last update.

## Operation
- Match rule: channel c matches when in_data_valid[c] is high AND in_data_dst_cell slice c equals {CELL_X,CELL_Y,CELL_Z}.
- Acceptance: inputs are accepted only when in_ready is high.
  - in_ready is registered and is high iff FIFO free slots >= NUM_CH after the current cycle's push and pop.
  - When in_ready is low, inputs are ignored; upstream holds them.
- FIFO push: all matches in one accepted cycle are pushed in ascending channel index, so channel 0 lands first.
- Drain: the FIFO pops one entry per cycle into the shadow bank at wr_ptr.
  - wr_ptr starts at 1 and increments per write.
  - When wr_ptr = PARTICLE_NUM+1, popped entries are discarded and out_overflow is set.
- FSM states:
  - IDLE: wr_ptr=1. When motion_update_enable=1, clear out_overflow and go to COLLECT; same-cycle matches are accepted.
  - COLLECT: accept and drain. Go to DRAIN when motion_update_enable=0; inputs in that cycle are not accepted.
  - DRAIN: pop until the FIFO is empty, then go to WRITE_NUM.
  - WRITE_NUM: write {zero-extended, wr_ptr-1} to shadow address 0, then go to SWAP.
  - SWAP: flip active_bank, pulse out_swap_done, go to IDLE.
- motion_update_enable is sampled only in IDLE. Re-assertion during DRAIN, WRITE_NUM or SWAP has no effect until IDLE is reached.
- Reads always target the active bank and are never blocked by writes, since the banks are separate.
- An update with zero matches still writes count 0 and swaps.
- Reset values: state IDLE, active_bank 0, FIFO empty, wr_ptr 1, in_ready 1, out_swap_done 0, out_overflow 0, out_particle_info 0.
- Bank contents are not cleared by reset. Bank 0 powers up with initial cell data via the memory init mechanism; bank 1 powers up with zeros.
- Reset mid-update: the FIFO is flushed, the partial shadow contents are abandoned, and bank 0 becomes active.

## Timing
- Read latency: 1 cycle from in_rden/in_read_address to out_particle_info. Output holds its value when in_rden=0.
- Match to shadow write: at least 2 cycles (FIFO push, then pop/write).
- Enable fall to out_swap_done: FIFO occupancy + 3 cycles (DRAIN exit, WRITE_NUM, SWAP).
- out_active_bank changes in the same cycle as out_swap_done. The first read issued in the following cycle returns new-bank data.

## Configuration
- POS_CACHE_READ_REG_EN defined: adds an output register stage; read latency becomes 2 cycles, and out_particle_info resets to 0.
- Not defined: 1-cycle latency as above.
- Bank swap timing is identical in both cases. A read issued in the SWAP cycle returns old-bank data.

## Test plan
- Reset, then read address 0 of bank 0 -> initial count after 1 cycle; out_active_bank=0, in_ready=1.
- NUM_CH=2, 5 cycles with both channels matching, then enable low -> shadow addresses 1..10 hold the data in ch0,ch1 order; count 10 at address 0; out_swap_done pulses exactly once; out_active_bank=1.
- PARTICLE_NUM=4, 6 matches -> address 0 = 4, out_overflow=1; out_overflow clears at the next enable rise.
- FIFO_DEPTH=4, NUM_CH=2, continuous matches on both channels -> in_ready deasserts; no match lost once the held inputs are accepted; final count equals the number of accepted matches.
- Non-matching dst_cell on every channel for a full window -> count 0 written, swap occurs, reads return 0 at address 0.
- Assert rst during DRAIN with 3 entries queued -> next cycle: IDLE, out_active_bank=0, FIFO empty, no out_swap_done pulse.
